// File: rtl/hilo_acc_unit_if.sv
// hilo_acc_unit_if: bundles the write, accumulate and read-port signals of the
// HI/LO register unit. The master side is the pipeline that drives requests;
// the slave side is the HI/LO unit itself.
interface hilo_acc_unit_if #(
    parameter int W = 32
);
    logic             flush;
    logic             wr_full;
    logic [2*W-1:0]   wr_full_data;
    logic             wr_hi;
    logic [W-1:0]     wr_data_hi;
    logic             wr_lo;
    logic [W-1:0]     wr_data_lo;
    logic             acc_valid;
    logic             acc_sub;
    logic [2*W-1:0]   acc_data;
    logic             acc_ready;
    logic             busy;
    logic             acc_done;
    logic             acc_abort;
    logic [1:0]       rd_sel;
    logic [W-1:0]     rd_data;
    logic [2*W-1:0]   hilo_q;

    modport master (
        output flush, wr_full, wr_full_data, wr_hi, wr_data_hi, wr_lo, wr_data_lo,
               acc_valid, acc_sub, acc_data, rd_sel,
        input  acc_ready, busy, acc_done, acc_abort, rd_data, hilo_q
    );

    modport slave (
        input  flush, wr_full, wr_full_data, wr_hi, wr_data_hi, wr_lo, wr_data_lo,
               acc_valid, acc_sub, acc_data, rd_sel,
        output acc_ready, busy, acc_done, acc_abort, rd_data, hilo_q
    );
endinterface

// File: rtl/hilo_acc_unit.sv
// hilo_acc_unit: HI:LO register pair for the multiply/divide datapath.
// Supports full-width and independent half writes, a forwarded MFHI/MFLO read
// port, and a two-cycle multiply-accumulate/subtract pipeline that splits the
// 2W-bit add into a low half (S_LO) and a high half with carry (S_HI).
module hilo_acc_unit #(
    parameter int W      = 32,
    parameter int ACC_EN = 1
) (
    input  logic          clk,
    input  logic          rst,
    hilo_acc_unit_if.slave hilo_if
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        S_LO = 2'd1,
        S_HI = 2'd2
    } state_e;

    localparam logic ACC_ON = (ACC_EN != 0);

    state_e          state_q, state_d;
    logic [2*W-1:0]  hilo_q, hilo_d;
    logic [2*W-1:0]  op_q, op_d;
    logic            sub_q, sub_d;
    logic [W-1:0]    lo_res_q, lo_res_d;
    logic            carry_q, carry_d;
    logic            done_q, done_d;
    logic            abort_q, abort_d;

    logic            direct_wr_s;
    logic [2*W-1:0]  direct_val_s;
    logic [W:0]      lo_sum_s;
    logic [W-1:0]    hi_sum_s;

    assign direct_wr_s = hilo_if.wr_full | hilo_if.wr_hi | hilo_if.wr_lo;

    // Value the register pair takes after this cycle's direct writes (also the forwarding source).
    always_comb begin
        direct_val_s = hilo_q;
        if (hilo_if.wr_full) begin
            direct_val_s = hilo_if.wr_full_data;
        end else begin
            if (hilo_if.wr_hi) begin
                direct_val_s[2*W-1:W] = hilo_if.wr_data_hi;
            end else begin
                direct_val_s[2*W-1:W] = hilo_q[2*W-1:W];
            end
            if (hilo_if.wr_lo) begin
                direct_val_s[W-1:0] = hilo_if.wr_data_lo;
            end else begin
                direct_val_s[W-1:0] = hilo_q[W-1:0];
            end
        end
    end

    // Split-width accumulate arithmetic: low half yields carry/borrow, high half consumes it.
    always_comb begin
        if (sub_q) begin
            lo_sum_s = {1'b0, hilo_q[W-1:0]} - {1'b0, op_q[W-1:0]};
            hi_sum_s = hilo_q[2*W-1:W] - op_q[2*W-1:W] - {{(W-1){1'b0}}, carry_q};
        end else begin
            lo_sum_s = {1'b0, hilo_q[W-1:0]} + {1'b0, op_q[W-1:0]};
            hi_sum_s = hilo_q[2*W-1:W] + op_q[2*W-1:W] + {{(W-1){1'b0}}, carry_q};
        end
    end

    // Accumulate FSM next state; a direct write or flush mid-flight cancels the operation.
    always_comb begin
        state_d  = state_q;
        hilo_d   = direct_val_s;
        op_d     = op_q;
        sub_d    = sub_q;
        lo_res_d = lo_res_q;
        carry_d  = carry_q;
        done_d   = 1'b0;
        abort_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (ACC_ON && hilo_if.acc_valid && !hilo_if.flush) begin
                    op_d    = hilo_if.acc_data;
                    sub_d   = hilo_if.acc_sub;
                    state_d = S_LO;
                end else begin
                    state_d = IDLE;
                end
            end
            S_LO: begin
                if (direct_wr_s || hilo_if.flush) begin
                    abort_d = 1'b1;
                    state_d = IDLE;
                end else begin
                    lo_res_d = lo_sum_s[W-1:0];
                    carry_d  = lo_sum_s[W];
                    state_d  = S_HI;
                end
            end
            S_HI: begin
                if (direct_wr_s || hilo_if.flush) begin
                    abort_d = 1'b1;
                    state_d = IDLE;
                end else begin
                    hilo_d  = {hi_sum_s, lo_res_q};
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            hilo_q   <= '0;
            op_q     <= '0;
            sub_q    <= 1'b0;
            lo_res_q <= '0;
            carry_q  <= 1'b0;
            done_q   <= 1'b0;
            abort_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            hilo_q   <= hilo_d;
            op_q     <= op_d;
            sub_q    <= sub_d;
            lo_res_q <= lo_res_d;
            carry_q  <= carry_d;
            done_q   <= done_d;
            abort_q  <= abort_d;
        end
    end

    // Forwarded read port: direct write data this cycle wins over the stored half.
    always_comb begin
        case (hilo_if.rd_sel)
            2'b01:   hilo_if.rd_data = direct_val_s[2*W-1:W];
            2'b10:   hilo_if.rd_data = direct_val_s[W-1:0];
            default: hilo_if.rd_data = '0;
        endcase
    end

    assign hilo_if.acc_ready = ACC_ON & (state_q == IDLE) & ~rst;
    assign hilo_if.busy      = (state_q != IDLE);
    assign hilo_if.acc_done  = done_q;
    assign hilo_if.acc_abort = abort_q;
    assign hilo_if.hilo_q    = hilo_q;

endmodule

// File: tb/tb_hilo_acc_unit.sv
// tb_hilo_acc_unit: directed vectors for hilo_acc_unit. Accumulate outcomes are
// pushed into a scoreboard queue by the stimulus; a monitor pops and compares on
// every acc_done/acc_abort pulse. Combinational/level checks are made inline.
module tb_hilo_acc_unit;
    localparam int W = 32;

    typedef struct packed {
        logic        is_abort;
        logic [63:0] hilo;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   bad0     = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    hilo_acc_unit_if #(.W(W)) bus ();
    hilo_acc_unit_if #(.W(W)) bus0 ();

    hilo_acc_unit #(.W(W), .ACC_EN(1)) dut  (.clk(clk), .rst(rst), .hilo_if(bus));
    hilo_acc_unit #(.W(W), .ACC_EN(0)) dut0 (.clk(clk), .rst(rst), .hilo_if(bus0));

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp_v);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        bus.flush = 1'b0; bus.wr_full = 1'b0; bus.wr_full_data = '0;
        bus.wr_hi = 1'b0; bus.wr_data_hi = '0; bus.wr_lo = 1'b0; bus.wr_data_lo = '0;
        bus.acc_valid = 1'b0; bus.acc_sub = 1'b0; bus.acc_data = '0;
    endtask

    task automatic write_full(input logic [63:0] v);
        bus.wr_full = 1'b1; bus.wr_full_data = v;
        step();
        bus.wr_full = 1'b0;
    endtask

    // Full accumulate: checks handshake levels each cycle, result via scoreboard.
    task automatic run_acc(input logic sub, input logic [63:0] d, input logic [63:0] expv);
        bus.acc_valid = 1'b1; bus.acc_sub = sub; bus.acc_data = d;
        exp_q.push_back({1'b0, expv});
        #1 check("ready_idle", bus.acc_ready, 1);
        step();
        bus.acc_valid = 1'b0;
        #1 check("busy_c1", bus.busy, 1);
        check("ready_c1", bus.acc_ready, 0);
        step();
        #1 check("busy_c2", bus.busy, 1);
        check("ready_c2", bus.acc_ready, 0);
        step();
        #1 check("busy_c3", bus.busy, 0);
        check("ready_c3", bus.acc_ready, 1);
        check("acc_hilo", bus.hilo_q, expv);
    endtask

    // Scoreboard monitor: every completion/abort pulse must match the next expectation.
    always @(negedge clk) begin
        exp_t e;
        if (bus.acc_done || bus.acc_abort) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_pulse: done=%0b abort=%0b, expected no pulse",
                         bus.acc_done, bus.acc_abort);
            end else begin
                e = exp_q.pop_front();
                check("pulse_kind", {62'd0, bus.acc_done, bus.acc_abort},
                      e.is_abort ? 64'd1 : 64'd2);
                check("pulse_hilo", bus.hilo_q, e.hilo);
            end
        end
        if (bus0.acc_done || bus0.acc_abort || bus0.busy) begin
            bad0++;
        end
    end

    initial begin
        clear_inputs();
        bus.rd_sel = 2'b00;
        bus0.flush = 1'b0; bus0.wr_full = 1'b0; bus0.wr_full_data = '0;
        bus0.wr_hi = 1'b0; bus0.wr_data_hi = '0; bus0.wr_lo = 1'b0; bus0.wr_data_lo = '0;
        bus0.acc_valid = 1'b1; bus0.acc_sub = 1'b0; bus0.acc_data = 64'd1; bus0.rd_sel = 2'b00;

        // Reset state
        step(); step();
        #1 check("rst_hilo", bus.hilo_q, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_ready", bus.acc_ready, 0);
        check("rst_rd", bus.rd_data, 0);
        check("rst_pulses", {bus.acc_done, bus.acc_abort}, 0);
        rst = 1'b0;
        #1 check("ready_after_rst", bus.acc_ready, 1);

        // Full write then read both halves
        write_full(64'h00000001_FFFFFFFF);
        bus.rd_sel = 2'b01;
        #1 check("rd_hi", bus.rd_data, 64'h1);
        bus.rd_sel = 2'b10;
        #1 check("rd_lo", bus.rd_data, 64'hFFFFFFFF);
        check("full_hilo", bus.hilo_q, 64'h00000001_FFFFFFFF);
        bus.rd_sel = 2'b11;
        #1 check("rd_none", bus.rd_data, 0);

        // HI write forwarded in the same cycle
        write_full(64'h00000001_00000002);
        bus.wr_hi = 1'b1; bus.wr_data_hi = 32'hDEADBEEF; bus.rd_sel = 2'b01;
        #1 check("fwd_hi", bus.rd_data, 64'hDEADBEEF);
        step();
        bus.wr_hi = 1'b0;
        #1 check("hi_write", bus.hilo_q, 64'hDEADBEEF_00000002);

        // Simultaneous HI and LO writes, LO forwarded
        bus.wr_hi = 1'b1; bus.wr_data_hi = 32'h0000AAAA;
        bus.wr_lo = 1'b1; bus.wr_data_lo = 32'h0000BBBB; bus.rd_sel = 2'b10;
        #1 check("fwd_lo", bus.rd_data, 64'h0000BBBB);
        step();
        clear_inputs();
        bus.rd_sel = 2'b00;
        #1 check("hi_lo_write", bus.hilo_q, 64'h0000AAAA_0000BBBB);

        // Accumulates: carry across halves, borrow wrap, wrap back, borrow across halves
        write_full(64'h00000000_FFFFFFFF);
        run_acc(1'b0, 64'h1, 64'h00000001_00000000);
        write_full(64'h0);
        run_acc(1'b1, 64'h1, 64'hFFFFFFFF_FFFFFFFF);
        run_acc(1'b0, 64'h2, 64'h00000000_00000001);
        write_full(64'h00000002_00000000);
        run_acc(1'b1, 64'h1, 64'h00000001_FFFFFFFF);

        // Abort by LO write in S_HI
        write_full(64'h12345678_9ABCDEF0);
        bus.acc_valid = 1'b1; bus.acc_sub = 1'b0; bus.acc_data = 64'h1;
        step();
        bus.acc_valid = 1'b0;
        step();
        bus.wr_lo = 1'b1; bus.wr_data_lo = 32'h55;
        exp_q.push_back({1'b1, 64'h12345678_00000055});
        step();
        bus.wr_lo = 1'b0;
        #1 check("abort_busy", bus.busy, 0);
        check("abort_ready", bus.acc_ready, 1);
        check("abort_hilo", bus.hilo_q, 64'h12345678_00000055);

        // Flush in S_LO aborts without writing
        bus.acc_valid = 1'b1; bus.acc_data = 64'h5;
        step();
        bus.acc_valid = 1'b0; bus.flush = 1'b1;
        exp_q.push_back({1'b1, 64'h12345678_00000055});
        step();
        bus.flush = 1'b0;
        #1 check("flush_busy", bus.busy, 0);

        // Flush in IDLE blocks acceptance, no pulse
        step();
        bus.acc_valid = 1'b1; bus.flush = 1'b1;
        step();
        bus.acc_valid = 1'b0; bus.flush = 1'b0;
        #1 check("flush_idle_busy", bus.busy, 0);
        step(); step();

        // Direct write in the accepting cycle feeds the accumulate
        bus.wr_full = 1'b1; bus.wr_full_data = 64'h5;
        bus.acc_valid = 1'b1; bus.acc_sub = 1'b0; bus.acc_data = 64'h3;
        exp_q.push_back({1'b0, 64'h8});
        step();
        clear_inputs();
        #1 check("wr_acc_busy", bus.busy, 1);
        step(); step();
        #1 check("wr_acc_hilo", bus.hilo_q, 64'h8);

        // Reset during S_LO
        bus.acc_valid = 1'b1; bus.acc_data = 64'h7;
        step();
        bus.acc_valid = 1'b0; rst = 1'b1;
        #1 check("mid_rst_ready", bus.acc_ready, 0);
        step();
        #1 check("mid_rst_hilo", bus.hilo_q, 0);
        check("mid_rst_busy", bus.busy, 0);
        check("mid_rst_pulses", {bus.acc_done, bus.acc_abort}, 0);
        rst = 1'b0;
        step(); step();
        #1 check("post_rst_ready", bus.acc_ready, 1);
        check("post_rst_hilo", bus.hilo_q, 0);

        // ACC_EN=0 instance: never ready, never busy, direct writes still work
        check("acc0_ready", bus0.acc_ready, 0);
        bus0.wr_full = 1'b1; bus0.wr_full_data = 64'hCAFE0000_0000F00D;
        step();
        bus0.wr_full = 1'b0;
        #1 check("acc0_hilo", bus0.hilo_q, 64'hCAFE0000_0000F00D);
        step(); step();
        check("acc0_activity", bad0, 0);

        // Every expected pulse must have been observed
        repeat (3) step();
        check("sb_drain", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
